// File: rtl/spike_hysteresis_unit.sv
// Multi-channel hysteretic spike generator: per-channel ARMED/REFRAC/DISARMED FSM
// with refractory down-counter, plus a saturating aggregate spike counter.

module spike_hyst_lane #(
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [WIDTH-1:0]    i_pot,
  input  logic [WIDTH-1:0]    i_thresh_low,
  input  logic [WIDTH-1:0]    i_thresh_high,
  input  logic [REFRAC_W-1:0] i_refrac_len,
  output logic                o_spk,
  output logic                o_spkblty
);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_REFRAC   = 2'd1,
    ST_DISARMED = 2'd2
  } state_t;

  state_t              r_state;
  logic [REFRAC_W-1:0] r_cnt;
  logic                r_spk;
  logic                r_spkblty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ARMED;
      r_cnt     <= '0;
      r_spk     <= 1'b0;
      r_spkblty <= 1'b1;
    end else begin
      r_spk <= 1'b0;
      if (i_valid) begin
        case (r_state)
          ST_ARMED: begin
            if (i_pot >= i_thresh_high) begin
              r_spk     <= 1'b1;
              r_spkblty <= 1'b0;
              if (i_refrac_len == '0) begin
                r_state <= ST_DISARMED;
              end else begin
                r_state <= ST_REFRAC;
                r_cnt   <= i_refrac_len;
              end
            end
          end
          ST_REFRAC: begin
            // Potential is ignored here; the last count leaves us DISARMED.
            if (r_cnt <= REFRAC_W'(1)) begin
              r_state <= ST_DISARMED;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - REFRAC_W'(1);
            end
          end
          ST_DISARMED: begin
            if (i_pot < i_thresh_low) begin
              r_state   <= ST_ARMED;
              r_spkblty <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_ARMED;
            r_cnt     <= '0;
            r_spkblty <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_spk     = r_spk;
  assign o_spkblty = r_spkblty;

endmodule

module spike_hysteresis_unit #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] potential,
  input  logic [WIDTH-1:0]          thresh_low,
  input  logic [WIDTH-1:0]          thresh_high,
  input  logic [REFRAC_W-1:0]       refrac_len,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       spk,
  output logic [CHANNELS-1:0]       spkblty,
  output logic [15:0]               spk_total
);

  localparam int PW = $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0][WIDTH-1:0] w_pot;
  logic [CHANNELS-1:0]            w_spk;
  logic [CHANNELS-1:0]            w_spkblty;
  logic [PW-1:0]                  w_pop;
  logic [16:0]                    w_sum;
  logic [15:0]                    r_spk_total;

  assign w_pot = potential;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    spike_hyst_lane #(
      .WIDTH    (WIDTH),
      .REFRAC_W (REFRAC_W)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .i_valid       (in_valid),
      .i_pot         (w_pot[g]),
      .i_thresh_low  (thresh_low),
      .i_thresh_high (thresh_high),
      .i_refrac_len  (refrac_len),
      .o_spk         (w_spk[g]),
      .o_spkblty     (w_spkblty[g])
    );
  end

  // Counts the spikes currently presented on spk, so the total lags spk by one cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pop = w_pop + PW'(w_spk[i]);
    end
  end

  assign w_sum = {1'b0, r_spk_total} + 17'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spk_total <= '0;
    end else if (cnt_clr) begin
      r_spk_total <= '0;
    end else begin
      r_spk_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign spk       = w_spk;
  assign spkblty   = w_spkblty;
  assign spk_total = r_spk_total;

endmodule

// File: tb/tb_spike_hysteresis_unit.sv
// Directed bench for spike_hysteresis_unit: behavioural model checked every
// cycle, plus literal expectations at the interesting points of each scenario.

module tb_spike_hysteresis_unit;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int RW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CH*W-1:0]   potential;
  logic [W-1:0]      thresh_low;
  logic [W-1:0]      thresh_high;
  logic [RW-1:0]     refrac_len;
  logic              cnt_clr;
  logic [CH-1:0]     spk;
  logic [CH-1:0]     spkblty;
  logic [15:0]       spk_total;

  int n_vec = 0;
  int n_err = 0;

  spike_hysteresis_unit #(.CHANNELS(CH), .WIDTH(W), .REFRAC_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .potential   (potential),
    .thresh_low  (thresh_low),
    .thresh_high (thresh_high),
    .refrac_len  (refrac_len),
    .cnt_clr     (cnt_clr),
    .spk         (spk),
    .spkblty     (spkblty),
    .spk_total   (spk_total)
  );

  always #5 clk = ~clk;

  // Model: a channel is either armed, or waiting out "skip" ignored samples
  // and then for a sample below the low threshold.
  bit [CH-1:0] m_armed;
  int          m_skip [CH];
  bit [CH-1:0] m_spk;
  int          m_total;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed = '1;
      m_spk   = '0;
      m_total = 0;
      for (int c = 0; c < CH; c++) m_skip[c] = 0;
    end else begin
      if (cnt_clr) m_total = 0;
      else begin
        m_total = m_total + $countones(m_spk);
        if (m_total > 65535) m_total = 65535;
      end
      m_spk = '0;
      if (in_valid) begin
        for (int c = 0; c < CH; c++) begin
          int p;
          p = int'(potential[c*W +: W]);
          if (m_armed[c]) begin
            if (p >= int'(thresh_high)) begin
              m_spk[c]  = 1'b1;
              m_armed[c] = 1'b0;
              m_skip[c] = int'(refrac_len);
            end
          end else if (m_skip[c] > 0) begin
            m_skip[c] = m_skip[c] - 1;
          end else if (p < int'(thresh_low)) begin
            m_armed[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_vec++;
      if (spk !== m_spk) begin
        n_err++;
        $display("FAIL model_spk t=%0t got %h exp %h", $time, spk, m_spk);
      end
      n_vec++;
      if (spkblty !== m_armed) begin
        n_err++;
        $display("FAIL model_spkblty t=%0t got %h exp %h", $time, spkblty, m_armed);
      end
      n_vec++;
      if (spk_total !== 16'(m_total)) begin
        n_err++;
        $display("FAIL model_total t=%0t got %h exp %h", $time, spk_total, 16'(m_total));
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pk(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Present one sample across the edge; outputs are settled on return.
  task automatic step(input logic v, input logic [CH*W-1:0] p, input logic clr = 1'b0);
    in_valid  = v;
    potential = p;
    cnt_clr   = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; potential = '0; cnt_clr = 1'b0;
    thresh_low = 8'd200; thresh_high = 8'd230; refrac_len = 4'd0;
    #1;
    chk("reset_spk", 16'(spk), 16'h0);
    chk("reset_blty", 16'(spkblty), 16'hF);
    chk("reset_total", spk_total, 16'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic fire / re-arm, refrac 0
    step(1, pk(100, 0, 0, 0));
    chk("t1_s1_spk", 16'(spk[0]), 16'h0);
    step(1, pk(231, 0, 0, 0));
    chk("t1_s2_spk", 16'(spk[0]), 16'h1);
    chk("t1_s2_blty", 16'(spkblty[0]), 16'h0);
    step(1, pk(231, 0, 0, 0));
    chk("t1_s3_spk", 16'(spk[0]), 16'h0);
    chk("t1_s3_blty", 16'(spkblty[0]), 16'h0);
    step(1, pk(199, 0, 0, 0));
    chk("t1_s4_spk", 16'(spk[0]), 16'h0);
    chk("t1_s4_blty", 16'(spkblty[0]), 16'h1);
    step(1, pk(230, 0, 0, 0));
    chk("t1_s5_spk", 16'(spk[0]), 16'h1);
    step(1, pk(0, 0, 0, 0));

    // Refractory of 3
    refrac_len = 4'd3;
    step(1, pk(10, 240, 10, 10));
    chk("t2_s1_spk", 16'(spk), 16'h2);
    for (int i = 2; i <= 4; i++) begin
      step(1, pk(10, 10, 10, 10));
      chk("t2_refrac_blty", 16'(spkblty[1]), 16'h0);
      chk("t2_refrac_spk", 16'(spk[1]), 16'h0);
    end
    step(1, pk(10, 10, 10, 10));
    chk("t2_s5_blty", 16'(spkblty[1]), 16'h1);
    step(1, pk(10, 240, 10, 10));
    chk("t2_s6_spk", 16'(spk), 16'h2);
    for (int i = 0; i < 4; i++) step(1, pk(0, 0, 0, 0));
    chk("t2_rearm", 16'(spkblty), 16'hF);

    // in_valid gap does not advance the refractory count
    step(1, pk(0, 0, 240, 0));
    chk("t3_fire", 16'(spk), 16'h4);
    for (int i = 0; i < 20; i++) begin
      step(0, pk(0, 0, 0, 0));
      chk("t3_gap_spk", 16'(spk), 16'h0);
      chk("t3_gap_blty", 16'(spkblty), 16'hB);
    end
    for (int i = 0; i < 3; i++) step(1, pk(0, 0, 0, 0));
    chk("t3_after_refrac", 16'(spkblty), 16'hB);
    step(1, pk(0, 0, 0, 0));
    chk("t3_rearm", 16'(spkblty), 16'hF);
    chk("t3_total", spk_total, 16'd5);

    // Simultaneous spikes, saturation, clear
    refrac_len = 4'd0;
    step(1, {4{8'd240}});
    chk("t4_all_spk", 16'(spk), 16'hF);
    chk("t4_total_lag", spk_total, 16'd5);
    step(1, '0);
    chk("t4_total_plus4", spk_total, 16'd9);
    for (int i = 0; i < 16381; i++) begin
      step(1, {4{8'd240}});
      step(1, '0);
    end
    chk("t4_preload", spk_total, 16'd65533);
    step(1, pk(240, 0, 0, 0));
    step(1, '0);
    chk("t4_fffe", spk_total, 16'hFFFE);
    step(1, {4{8'd240}});
    step(1, '0);
    chk("t4_ffff", spk_total, 16'hFFFF);
    step(1, {4{8'd240}});
    step(1, '0);
    chk("t4_sat_hold", spk_total, 16'hFFFF);
    step(1, {4{8'd240}});
    chk("t4_clr_spk", 16'(spk), 16'hF);
    step(1, '0, 1'b1);
    chk("t4_clr", spk_total, 16'h0);
    step(1, '0);
    chk("t4_clr_dropped", spk_total, 16'h0);

    // Inverted thresholds
    thresh_low = 8'd230; thresh_high = 8'd200;
    step(1, {4{8'd210}});
    chk("t5_s1", 16'(spk), 16'hF);
    step(1, {4{8'd210}});
    chk("t5_s2", 16'(spk), 16'h0);
    chk("t5_s2_blty", 16'(spkblty), 16'hF);
    step(1, {4{8'd210}});
    chk("t5_s3", 16'(spk), 16'hF);

    // Async reset mid-refractory with spk high
    thresh_low = 8'd200; thresh_high = 8'd230; refrac_len = 4'd5;
    step(1, '0);
    step(1, {4{8'd250}});
    chk("t6_pre_spk", 16'(spk), 16'hF);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_spk", 16'(spk), 16'h0);
    chk("t6_rst_blty", 16'(spkblty), 16'hF);
    chk("t6_rst_total", spk_total, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1, {4{8'd250}});
    chk("t6_fire_after", 16'(spk), 16'hF);
    step(1, '0);
    chk("t6_total", spk_total, 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_hysteresis_unit.md
# spike_hysteresis_unit

Multi-channel hysteretic spike generator for the SNN neuron array. Each channel compares its membrane potential against a programmable high/low threshold pair. It emits a one-cycle spike on an upward crossing, then holds off for a programmable refractory period. It re-arms only once the potential has fallen below the low threshold. Sits between the neuron potential accumulators and the spike routing/event logic, and provides a saturating aggregate spike count for debug and activity monitoring.

## Interface

Parameters:
- CHANNELS, 4, number of independent neuron channels
- WIDTH, 8, potential and threshold width (unsigned)
- REFRAC_W, 4, refractory-length counter width

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  potential sample strobe (one timestep); all channels sampled together
- potential  input  CHANNELS*WIDTH  packed potentials; channel i at [i*WIDTH +: WIDTH]
- thresh_low  input  WIDTH  re-arm threshold, shared by all channels
- thresh_high  input  WIDTH  fire threshold, shared by all channels
- refrac_len  input  REFRAC_W  refractory length in valid samples, 0 = none
- cnt_clr  input  1  synchronous clear of spk_total
- spk  output  CHANNELS  registered one-cycle spike pulse per channel
- spkblty  output  CHANNELS  registered "spike-able": channel is ARMED
- spk_total  output  16  saturating count of all spikes emitted

## Operation

- Per-channel FSM with states ARMED, REFRAC, DISARMED, plus a REFRAC_W-bit down-counter. Channels are fully independent.
- State changes only on cycles with in_valid=1. With in_valid=0, state, counter and spkblty hold, and spk is 0.
- ARMED: if potential >= thresh_high, then spk=1 next cycle. If refrac_len=0, go to DISARMED; otherwise go to REFRAC with cnt=refrac_len. Otherwise stay ARMED.
- REFRAC: on each valid sample, if cnt<=1 go to DISARMED, else cnt=cnt-1. Potential is ignored. Net effect: refrac_len valid samples are ignored after the firing sample.
- DISARMED: if potential < thresh_low, go to ARMED; otherwise stay. The sample that arms is not compared against thresh_high. Firing needs a later sample.
- Comparisons are unsigned. Equality to thresh_high fires; equality to thresh_low does not re-arm.
- If thresh_low > thresh_high there is no special handling. The same rules apply, so a channel can re-arm on its next valid sample.
- refrac_len, thresh_low and thresh_high are sampled live each cycle. refrac_len is latched into cnt only on entry to REFRAC; later changes do not affect a running count.
- spkblty[i] = (state_i == ARMED), registered.
- spk_total: each cycle, add popcount(spk), i.e. the spikes being presented that cycle. Saturates at 16'hFFFF and never wraps. cnt_clr=1 forces 0 and has priority; spikes presented in the clear cycle are dropped.

## Timing

- Reset values (asynchronous, immediate): all channels ARMED, cnt=0, spk=0, spkblty=all ones, spk_total=0.
- Latency: a valid sample at edge N produces spk/spkblty changes visible after edge N. For example, spk is high for exactly the cycle following the triggering sample.
- spk_total reflects a spike one cycle after spk asserts, i.e. two cycles after the triggering sample.
- Back-to-back valid samples are supported at full rate. There is no backpressure.
- Minimum spacing between spikes on one channel, counted in valid samples: 1 firing sample + refrac_len refractory samples + at least 1 re-arm sample + 1 firing sample.
- Reset asserted mid-REFRAC or with spk high: outputs go to reset values at once. The in-flight spike is lost and not counted.
- Simultaneous spikes on several channels in one cycle are all counted. For example, with CHANNELS=4 all firing, spk_total increases by 4, clipped at FFFF.

## Test plan

- Basic fire/re-arm (CHANNELS=4, WIDTH=8, low=200, high=230, refrac_len=0). Ch0 samples 100, 231, 231, 199, 230 -> spk0 high after samples 2 and 5 only; spkblty0 low after sample 2, high after sample 4.
- Refractory (refrac_len=3). Ch1 samples 240, 10, 10, 10, 10, 240 -> one spike after sample 1; DISARMED after sample 4; re-armed after sample 5; spike after sample 6. spkblty1 stays low through sample 4.
- in_valid gaps. Fire, then hold in_valid=0 for 20 cycles with potential=0 -> REFRAC count does not advance and spk pulses once only; spkblty is unchanged during the gap.
- Simultaneous, saturation and clear. All 4 channels fire on one sample -> spk=4'hF for 1 cycle, and spk_total +4 the following cycle. Preload to FFFE via repeated spikes, then fire 4 -> FFFF. Assert cnt_clr concurrently with a spike -> spk_total=0.
- Inverted thresholds (low=230, high=200). Samples 210, 210, 210 -> fire, re-arm, fire, at one spike per two samples.
- Async reset during REFRAC with spk high -> spk=0, spkblty=F, spk_total=0 with no clock edge. The first sample of 250 after release fires immediately.
